// File: rtl/mux_arb_reg_n_if.sv
// Handshake/bus bundle for mux_arb_reg_n.
//   slave  : the selector's view (sources + downstream in, grants + register out)
//   master : the driver's view (testbench or surrounding pipeline)
// Signals: mode, sel, in_valid/in_data/in_ready (NUM_IN sources, flattened data),
//          out_valid/out_data/out_src/out_ready, err_sel.
interface mux_arb_reg_n_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
);
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_src;
  logic                    out_ready;
  logic                    err_sel;

  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src, err_sel
  );

  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src, err_sel
  );
endinterface

// File: rtl/mux_arb_reg_n.sv
// Registered N-to-1 selector with direct-select and round-robin modes.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - mux_arb_reg_n_if.slave: mode, sel, in_valid/in_data/in_ready,
//          out_valid/out_data/out_src/out_ready, err_sel
// One output register; in_ready is combinational from the current grant and
// the register's load condition, so a full register drains and refills in
// the same cycle. NUM_IN must not exceed 2**SEL_W.

// Per-source request decode: direct-select match and "above the RR pointer".
module mux_arb_reg_n_lane #(
  parameter int SEL_W = 2,
  parameter int IDX   = 0
) (
  input  logic             valid,
  input  logic [SEL_W-1:0] sel,
  input  logic [SEL_W-1:0] last,
  output logic             dir_req,
  output logic             hi_req
);
  localparam logic [SEL_W-1:0] ID = SEL_W'(IDX);

  assign dir_req = valid && (sel == ID);
  assign hi_req  = valid && (ID > last);
endmodule

module mux_arb_reg_n #(
  parameter int               WIDTH       = 32,
  parameter int               NUM_IN      = 4,
  parameter int               SEL_W       = 2,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
  input logic            clk,
  input logic            rst,
  mux_arb_reg_n_if.slave bus
);
  localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);

  logic              vld_q, err_q;
  logic [WIDTH-1:0]  data_q;
  logic [SEL_W-1:0]  src_q, last;
  logic              load, sel_ok, xfer;
  logic [NUM_IN-1:0] dir_req, hi_req, req, grant;
  logic [SEL_W-1:0]  gidx;
  logic [WIDTH-1:0]  gdata;

  assign load   = !vld_q || bus.out_ready;
  assign sel_ok = ({1'b0, bus.sel} < NUM_IN_W);

  for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
    mux_arb_reg_n_lane #(.SEL_W(SEL_W), .IDX(i)) u_lane (
      .valid   (bus.in_valid[i]),
      .sel     (bus.sel),
      .last    (last),
      .dir_req (dir_req[i]),
      .hi_req  (hi_req[i])
    );
  end

  // Round-robin: prefer valid sources above last; if none, wrap and take the
  // lowest valid index. Either way the lowest set bit of req wins.
  always_comb begin
    grant = '0;
    req   = '0;
    gidx  = '0;
    gdata = '0;
    if (!bus.mode) begin
      if (sel_ok) grant = dir_req;  // at most one lane matches sel
    end else begin
      req = (|hi_req) ? hi_req : bus.in_valid;
      for (int i = NUM_IN-1; i >= 0; i--) begin
        if (req[i]) begin
          grant    = '0;
          grant[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant[i]) begin
        gidx  = SEL_W'(i);
        gdata = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign xfer         = load && (|grant);
  assign bus.in_ready = load ? grant : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= DEFAULT_VAL;
      src_q  <= '0;
      err_q  <= 1'b0;
      last   <= SEL_W'(NUM_IN-1);
    end else begin
      // flags a bad direct select even while the register is stalled
      err_q <= !bus.mode && !sel_ok;
      if (load) begin
        vld_q <= xfer;
        if (xfer) begin
          data_q <= gdata;
          src_q  <= gidx;
        end
      end
      // only round-robin transfers move the fairness pointer
      if (xfer && bus.mode) last <= gidx;
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;
  assign bus.err_sel   = err_q;
endmodule

// File: tb/tb_mux_arb_reg_n.sv
module tb_mux_arb_reg_n;
  logic        clk, rst;
  logic        mode, ordy;
  logic [1:0]  sel;
  logic [3:0]  vld;
  logic [31:0] dat [4];

  int total, bad;

  // reference state per instance: 0 = 4 sources, 1 = 3 sources
  bit          m_v [2];
  logic [31:0] m_d [2];
  int          m_s [2];
  bit          m_e [2];
  int          m_l [2];

  mux_arb_reg_n_if #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) b4 ();
  mux_arb_reg_n_if #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) b3 ();

  assign b4.mode      = mode;
  assign b4.sel       = sel;
  assign b4.in_valid  = vld;
  assign b4.in_data   = {dat[3], dat[2], dat[1], dat[0]};
  assign b4.out_ready = ordy;
  assign b3.mode      = mode;
  assign b3.sel       = sel;
  assign b3.in_valid  = vld[2:0];
  assign b3.in_data   = {dat[2], dat[1], dat[0]};
  assign b3.out_ready = ordy;

  mux_arb_reg_n #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .DEFAULT_VAL(32'h0)) dut4 (
    .clk (clk), .rst (rst), .bus (b4.slave));
  mux_arb_reg_n #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .DEFAULT_VAL(32'h0)) dut3 (
    .clk (clk), .rst (rst), .bus (b3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // granted source index, or -1 for none
  function automatic int gnt(input int n, input bit md, input int s,
                             input logic [3:0] v, input int lst);
    if (!md) return (s < n && v[s]) ? s : -1;
    for (int k = 1; k <= n; k++) begin
      int j;
      j = (lst + k) % n;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    for (int u = 0; u < 2; u++) begin
      m_v[u] = 0; m_d[u] = 32'h0; m_s[u] = 0; m_e[u] = 0;
      m_l[u] = (u == 0) ? 3 : 2;
    end
  endfunction

  // one clock: inputs already driven just after a falling edge
  task automatic cyc();
    int g [2];
    int er [2];
    #1;
    for (int u = 0; u < 2; u++) begin
      bit ld;
      g[u]  = gnt((u == 0) ? 4 : 3, mode, int'(sel), vld, m_l[u]);
      ld    = !m_v[u] || ordy;
      er[u] = (ld && g[u] >= 0) ? (1 << g[u]) : 0;
    end
    chk("rdy4", b4.in_ready, er[0]);
    chk("rdy3", b3.in_ready, er[1]);
    @(posedge clk);
    for (int u = 0; u < 2; u++) begin
      int n;
      bit ld;
      n = (u == 0) ? 4 : 3;
      ld = !m_v[u] || ordy;
      m_e[u] = !mode && (int'(sel) >= n);
      if (ld) begin
        if (g[u] >= 0) begin
          m_v[u] = 1; m_d[u] = dat[g[u]]; m_s[u] = g[u];
          if (mode) m_l[u] = g[u];
        end else m_v[u] = 0;
      end
    end
    #1;
    chk("vld4", b4.out_valid, m_v[0]);
    chk("dat4", b4.out_data,  m_d[0]);
    chk("src4", b4.out_src,   m_s[0]);
    chk("err4", b4.err_sel,   m_e[0]);
    chk("vld3", b3.out_valid, m_v[1]);
    chk("dat3", b3.out_data,  m_d[1]);
    chk("src3", b3.out_src,   m_s[1]);
    chk("err3", b3.err_sel,   m_e[1]);
    @(negedge clk);
  endtask

  // asynchronous reset pulse placed between clock edges
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_vld", b4.out_valid, 0);
    chk("rst_dat", b4.out_data, 32'h0);
    chk("rst_src", b4.out_src, 0);
    chk("rst_err", b4.err_sel, 0);
    chk("rst_vld3", b3.out_valid, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; mode = 0; sel = 0; vld = 0; ordy = 0;
    for (int i = 0; i < 4; i++) dat[i] = 32'h0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("init_vld", b4.out_valid, 0);
    chk("init_dat", b4.out_data, 32'h0);
    chk("init_err", b4.err_sel, 0);
    rst = 1'b0;

    // direct select of source 2
    mode = 0; sel = 2; vld = 4'b0100; dat[2] = 32'hDEADBEEF; ordy = 1;
    #1 chk("t1_rdy", b4.in_ready, 4'b0100);
    cyc();
    chk("t1_vld", b4.out_valid, 1);
    chk("t1_dat", b4.out_data, 32'hDEADBEEF);
    chk("t1_src", b4.out_src, 2);

    // backpressure holds the register, then drains and refills with no bubble
    sel = 0; vld = 4'b0001; dat[0] = 32'h11111111;
    cyc();
    ordy = 0; sel = 1; vld = 4'b0010; dat[1] = 32'h22222222;
    for (int k = 0; k < 3; k++) begin
      #1 chk("t2_rdy", b4.in_ready, 0);
      cyc();
      chk("t2_hold", b4.out_data, 32'h11111111);
    end
    ordy = 1;
    cyc();
    chk("t2_new", b4.out_data, 32'h22222222);
    chk("t2_vld", b4.out_valid, 1);

    // round-robin fairness from reset pointer
    mode = 1; vld = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("t3_src", b4.out_src, k % 4);
    end

    // gaps and a stall: 1, 3, (stall), 1
    do_reset();
    mode = 1; vld = 4'b1010; ordy = 1;
    cyc(); chk("t4_a", b4.out_src, 1);
    cyc(); chk("t4_b", b4.out_src, 3);
    ordy = 0;
    cyc(); chk("t4_stall", b4.out_src, 3);
    cyc(); chk("t4_stall", b4.out_src, 3);
    ordy = 1;
    cyc(); chk("t4_c", b4.out_src, 1);

    // out-of-range direct select on the 3-source instance
    mode = 0; sel = 3; vld = 4'b0111; ordy = 1;
    #1 chk("t5_rdy", b3.in_ready, 0);
    cyc();
    chk("t5_err", b3.err_sel, 1);
    chk("t5_vld", b3.out_valid, 0);
    sel = 0;
    cyc();
    chk("t5_err_clr", b3.err_sel, 0);

    // async reset mid-stream, then first RR grant goes to source 0
    mode = 1; vld = 4'b1111;
    cyc(); cyc();
    chk("t6_pre", b4.out_valid, 1);
    do_reset();
    cyc();
    chk("t6_src", b4.out_src, 0);
    chk("t6_vld", b4.out_valid, 1);

    // randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 63) == 0) do_reset();
      mode = 1'($urandom_range(0, 1));
      sel  = 2'($urandom_range(0, 3));
      vld  = 4'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) dat[i] = $urandom;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
